// File: rtl/intr_pkg.sv
// Shared constants for the interrupt controller: register offsets, request count and FSM encoding.
package intr_pkg;

    localparam int NIRQ = 4;
    localparam int IDW  = $clog2(NIRQ);

    localparam int unsigned OFF_IMR = 32'h0;
    localparam int unsigned OFF_IPR = 32'h4;
    localparam int unsigned OFF_ISR = 32'h8;
    localparam int unsigned OFF_EOI = 32'hC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: the lowest-numbered active request wins, so bit 0 (timer) is highest.
module intr_prio_enc
    import intr_pkg::*;
(
    input  logic [NIRQ-1:0] req,
    output logic            valid,
    output logic [IDW-1:0]  id
);

    // Scanning from the top down lets the lowest set bit overwrite any higher one.
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctl.sv
// Memory-mapped interrupt controller: edge-detected pending bits, an enable mask and a
// three-state offer/acknowledge/end-of-interrupt handshake with the CPU.
module intr_ctl
    import intr_pkg::*;
#(
    parameter int             BITS = 32,
    parameter logic [BITS-1:0] BASE = BITS'(32'hF0000800)
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [BITS-1:0] ABUS,
    inout  wire  [BITS-1:0] DBUS,
    input  logic            WE,
    input  logic [NIRQ-1:0] IRQ,
    input  logic            INTA,
    output logic            INTR,
    output logic [IDW-1:0]  INTID
);

    localparam logic [BITS-1:0] ADDR_IMR = BASE + BITS'(OFF_IMR);
    localparam logic [BITS-1:0] ADDR_IPR = BASE + BITS'(OFF_IPR);
    localparam logic [BITS-1:0] ADDR_ISR = BASE + BITS'(OFF_ISR);
    localparam logic [BITS-1:0] ADDR_EOI = BASE + BITS'(OFF_EOI);

    state_t          state;
    logic [NIRQ-1:0] imr;
    logic [NIRQ-1:0] ipr;
    logic [NIRQ-1:0] ipr_next;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] rise;
    logic [IDW-1:0]  intid_q;
    logic            pend_valid;
    logic [IDW-1:0]  pend_id;
    logic            sel_imr;
    logic            sel_ipr;
    logic            sel_isr;
    logic            sel_eoi;
    logic            wr_imr;
    logic            wr_ipr;
    logic            wr_eoi;
    logic            ack;
    logic            rd_en;
    logic [BITS-1:0] rdata;

    assign sel_imr = (ABUS == ADDR_IMR);
    assign sel_ipr = (ABUS == ADDR_IPR);
    assign sel_isr = (ABUS == ADDR_ISR);
    assign sel_eoi = (ABUS == ADDR_EOI);

    assign wr_imr = WE & sel_imr;
    assign wr_ipr = WE & sel_ipr;
    assign wr_eoi = WE & sel_eoi;

    assign rise = IRQ & ~irq_q;
    assign ack  = (state == ST_REQ) & INTA;

    intr_prio_enc u_prio (
        .req   (ipr & imr),
        .valid (pend_valid),
        .id    (pend_id)
    );

    // Clears are applied first so that a fresh edge on the same bit always survives.
    always_comb begin
        ipr_next = ipr;
        if (wr_ipr) begin
            ipr_next = ipr_next & ~DBUS[NIRQ-1:0];
        end
        if (ack) begin
            ipr_next[intid_q] = 1'b0;
        end
        ipr_next = ipr_next | rise;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            imr     <= '0;
            ipr     <= '0;
            irq_q   <= '0;
            intid_q <= '0;
        end else begin
            irq_q <= IRQ;
            ipr   <= ipr_next;
            if (wr_imr) begin
                imr <= DBUS[NIRQ-1:0];
            end
            case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        intid_q <= pend_id;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (INTA) begin
                        state <= ST_SERVICE;
                    end else if (!imr[intid_q]) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (wr_eoi) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign INTR  = (state == ST_REQ);
    assign INTID = intid_q;

    // Read mux; EOI is write-only so it never drives the bus.
    always_comb begin
        rdata = '0;
        if (sel_imr) begin
            rdata[NIRQ-1:0] = imr;
        end else if (sel_ipr) begin
            rdata[NIRQ-1:0] = ipr;
        end else if (sel_isr) begin
            rdata[IDW]      = (state == ST_SERVICE);
            rdata[IDW-1:0]  = intid_q;
        end
    end

    assign rd_en = RESET_N & ~WE & (sel_imr | sel_ipr | sel_isr);
    assign DBUS  = rd_en ? rdata : {BITS{1'bz}};

endmodule

// File: doc/intr_ctl.md
INTR_CTL -- requirements
Module: intr_ctl

Interface
REQ-001 Parameter BITS, 32, bus address/data width.
REQ-002 Parameter BASE, 32'hF0000800, base address of the controller register block.
REQ-003 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-004 RESET_N  input  1  reset, asynchronous and active-low.
REQ-005 ABUS  input  BITS  memory-mapped address bus.
REQ-006 DBUS  inout  BITS  shared data bus; driven only on a selected read, else high-Z.
REQ-007 WE  input  1  bus write enable; 0 means read.
REQ-008 IRQ  input  4  level request lines from devices (bit 0 = timer, bits 1-3 = other devices).
REQ-009 INTA  input  1  CPU interrupt-acknowledge, one-cycle pulse.
REQ-010 INTR  output  1  interrupt request to CPU.
REQ-011 INTID  output  2  ID of the request being offered or serviced.

Function
REQ-012 Register map SHALL be: IMR at BASE (R/W, bits[3:0] enable mask), IPR at BASE+4 (R; write-1-to-clear bits[3:0]), ISR at BASE+8 (R; bit 2 = in-service flag, bits[1:0] = INTID), EOI at BASE+'hC (write only, any data).
REQ-013 Reads SHALL return the register zero-extended to BITS; writes SHALL take effect at the posedge CLK where WE=1 and the address matches; unmapped addresses SHALL be ignored.
REQ-014 Each IRQ[i] SHALL be registered every cycle; a 0->1 change versus the registered copy SHALL set IPR[i] at that same edge (rising-edge detect, one-cycle latency).
REQ-015 When an edge set and a W1C clear hit the same IPR bit in one cycle, the set SHALL win.
REQ-016 FSM states SHALL be IDLE, REQ and SERVICE.
REQ-017 IDLE: if (IPR & IMR) != 0, the FSM SHALL latch the winning ID into INTID and enter REQ at the next edge.
REQ-018 Fixed priority: the lowest-numbered set bit SHALL win, so the timer (bit 0) is highest.
REQ-019 INTR SHALL be 1 exactly while the state is REQ (decoded from the state register, no glitch path).
REQ-020 REQ + INTA: the FSM SHALL clear IPR[INTID], enter SERVICE and drop INTR at that edge.
REQ-021 REQ with IMR[INTID] cleared by a bus write and no INTA: the FSM SHALL return to IDLE with IPR unchanged.
REQ-022 SERVICE: INTID SHALL be held; new edges SHALL accumulate in IPR; a write to EOI SHALL return the FSM to IDLE.
REQ-023 INTA outside REQ and EOI outside SERVICE SHALL be ignored.
REQ-024 A new edge on the serviced bit during INTA SHALL leave IPR set (set beats ack clear).
REQ-025 From IDLE, the earliest INTR SHALL be 2 edges after the IRQ rise: IPR set at edge k, REQ entered at edge k+1.

Reset
REQ-026 While RESET_N=0: state=IDLE, IMR=0, IPR=0, IRQ copies=0, INTID=0, INTR=0, DBUS=Z.
REQ-027 Reset asserted mid-REQ or mid-SERVICE SHALL abort immediately, with no pending or in-service state retained.

Structure
REQ-028 Shared package intr_pkg SHALL hold the register offsets (0, 4, 8, 'hC), the FSM state encoding and the NIRQ=4 constant.
REQ-029 One sub-module intr_prio_enc (4-bit request in -> valid + 2-bit ID, combinational) SHALL be instantiated once.

Verification
REQ-030 Write IMR=4'hF; pulse IRQ[0] -> IPR=1 one edge later, INTR=1 and INTID=0 the following edge; INTA -> INTR=0, ISR=3'b100.
REQ-031 IMR=4'hF; raise IRQ[3] and IRQ[1] in the same cycle -> INTID=1 first; INTA + EOI -> INTID=3 offered next.
REQ-032 IMR=4'h0; pulse IRQ[2] -> IPR=4'h4, INTR stays 0; write IMR=4'h4 -> INTR=1, INTID=2.
REQ-033 In SERVICE (ID 0), raise IRQ[0] again -> IPR[0]=1, INTR=0; EOI -> INTR=1 two edges later.
REQ-034 In REQ, write IPR W1C=4'h1 in the same cycle as a new IRQ[0] edge -> IPR[0] stays 1.
REQ-035 Assert RESET_N=0 during SERVICE -> INTR=0, IMR=IPR=0 immediately; read of BASE+8 after release returns 0.
